spi_slave: RTL and testbench
============================

# spi_slave

Oversampled SPI slave (mode 0, CPOL=0/CPHA=0) that is the far end of the team's `spi_master`. It runs entirely in one system clock domain, synchronizing the external SCLK/CS/MOSI pins, and delivers received bytes on a 9-bit parallel port with a start-of-frame flag. It shifts MISO from a single-entry transmit holding register. It serves both as a sensor-side register-access target and as the loopback responder in the `spi_master` bench.

## Interface
Parameters:
- `SPI_FIRST_DATA`, default "MSB": "MSB" or "LSB" first on the wire, applies to both MOSI and MISO.
- `SPI_CS_POL`, default 0: 0 means CS is active-low, 1 means active-high.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock; must be ≥ 8× the SPI clock frequency.
- `reset` in 1: asynchronous, active-high reset.
- `i_spi_clk` in 1: SPI clock from the master, asynchronous to `clk`.
- `i_spi_cs` in 1: chip select, polarity set by `SPI_CS_POL`.
- `i_spi_mosi` in 1: master-out data.
- `o_spi_miso` out 1: slave-out data.
- `o_spi_miso_oe` out 1: MISO output enable; the pad tristates when this is 0.
- `ov_rx_data` out 9: bit 8 is 1 on the first byte of a frame; bits 7:0 are the received byte.
- `o_rx_valid` out 1: one-cycle strobe; `ov_rx_data` is valid in that cycle.
- `iv_tx_data` in 8: next byte to transmit.
- `i_tx_wr` in 1: write strobe into the transmit holding register.
- `o_tx_empty` out 1: transmit holding register is free.
- `o_tx_underrun` out 1: one-cycle pulse when a byte load finds no data.
- `o_frame_active` out 1: CS is asserted (synchronized).
- `o_frame_end` out 1: one-cycle pulse on CS deassertion.

## Operation
- **Synchronizing the pins:** `i_spi_clk`, `i_spi_cs` and `i_spi_mosi` each pass through 2 flops, then a 3rd history flop.
  - `sclk_rise`, `sclk_fall`, `cs_on` and `cs_off` are decoded from the 2nd and 3rd flops.
  - MOSI is sampled from its 2nd flop in the `sclk_rise` cycle.
- **States:**
  - IDLE to ACTIVE on `cs_on`.
  - ACTIVE to IDLE on `cs_off` (takes priority over any edge in the same cycle).
  - SCLK edges are ignored while in IDLE.
- **RX:**
  - A 3-bit bit counter advances on each `sclk_rise` while ACTIVE.
  - MOSI shifts into the RX shift register: in at bit 0 with left shift for "MSB", in at bit 7 with right shift for "LSB".
  - On the 8th rise (counter 7 wraps to 0), the next cycle sets `ov_rx_data` = {first_flag, byte} and `o_rx_valid` = 1.
  - first_flag is set by `cs_on` and cleared after the first `o_rx_valid` of the frame.
- **TX load points:** `cs_on`, and the first `sclk_fall` after a byte completes (byte_done flag).
  - At a load point: if the holding register is full, it transfers into the TX shift register and `o_tx_empty` goes to 1.
  - Else, if `i_tx_wr` is high in that same cycle, `iv_tx_data` bypasses straight into the shift register and the holding register stays empty.
  - Else, 0x00 is loaded and `o_tx_underrun` pulses.
- **TX shifting:** any other `sclk_fall` in ACTIVE shifts the TX register by one bit toward the output end.
- **MISO:** `o_spi_miso` is the output-end bit (bit 7 for "MSB", bit 0 for "LSB"). `o_spi_miso_oe` = `o_frame_active`.
- **Holding register:**
  - `i_tx_wr` while `o_tx_empty`=1 captures `iv_tx_data` and sets `o_tx_empty`=0.
  - `i_tx_wr` while full is dropped with no side effects.
  - The holding register survives across frames.
- **CS deasserted mid-byte:** the partial byte is discarded with no `o_rx_valid`; the bit counter, byte_done and first_flag are cleared. The TX shift register is not reloaded until the next `cs_on`.
- **Reset values:**
  - `o_spi_miso`=0, `o_spi_miso_oe`=0, `ov_rx_data`=0, `o_rx_valid`=0.
  - `o_tx_empty`=1, `o_tx_underrun`=0, `o_frame_active`=0, `o_frame_end`=0.
  - All shift registers and counters are 0, and the state is IDLE.
- **Reset mid-frame:** the block returns to IDLE immediately. If CS is still asserted when reset releases, it is not treated as a frame: a fresh deassert/assert is required.

## Timing
- Edge detect latency: 3 `clk` after the raw pin transition is first sampled.
- `o_rx_valid`: 1 `clk` after the detect cycle of the 8th `sclk_rise`, i.e. 4 `clk` after the raw edge.
- MISO update: 1 `clk` after a `cs_on` or `sclk_fall` detect. The master therefore sees the data ≥ half an SPI period minus 4 `clk` before the next rising edge; this is the basis of the ≥ 8× clock ratio.
- `o_frame_active` rises and falls with the `cs_on`/`cs_off` detect cycle. `o_frame_end` pulses in the `cs_off` detect cycle.
- The `o_tx_empty` refill window after a load is a full byte time.

## Test plan
- **Single frame, MSB first:** CS active-low, master sends 0xA5 then 0x3C; holding register preloaded with 0x5A, then 0xC3 written after `o_tx_empty` rises → `ov_rx_data` = 0x1A5 then 0x03C; MISO carries 0x5A then 0xC3; no underrun.
- **LSB first, `SPI_CS_POL`=1:** master sends 0x01 → `ov_rx_data` = 0x101; the first MOSI bit lands in bit 0.
- **Underrun:** no `i_tx_wr` before the second byte → `o_tx_underrun` pulses once at the load point; MISO = 0x00 for that byte.
- **Bypass and overflow:** `i_tx_wr` with 0x77 in the same cycle as an empty-register load → MISO = 0x77 and `o_tx_empty` stays 1. Then two `i_tx_wr` back-to-back (0x11, 0x22) → the register holds 0x11 and 0x22 is dropped.
- **Abort and reset:**
  - CS deasserted after 5 bits → no `o_rx_valid`, `o_frame_end` pulses; the next frame's first byte has bit 8 = 1.
  - `reset` asserted mid-byte → all outputs return to their reset values and the byte in progress is lost.

Source files
------------

// File: rtl/spi_slave.sv
// Mode-0 SPI slave oversampled in the clk domain: 9-bit RX byte port with a first-of-frame flag, MISO fed from a one-entry TX holding register.
// Latency: pin edges are detected 3 clk after first sample, o_rx_valid follows 1 clk later, and MISO updates 1 clk after a detected SCLK fall or CS assert.
// Backpressure: none on RX; a TX load that finds no data sends 0x00 and pulses o_tx_underrun, and a write to a full holding register is dropped.
module spi_slave #(
  parameter SPI_FIRST_DATA = "MSB",
  parameter int SPI_CS_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_spi_clk,
  input  logic       i_spi_cs,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  output logic [8:0] ov_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] iv_tx_data,
  input  logic       i_tx_wr,
  output logic       o_tx_empty,
  output logic       o_tx_underrun,
  output logic       o_frame_active,
  output logic       o_frame_end
);

  localparam bit MSB_FIRST = (SPI_FIRST_DATA == "MSB");

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       first_flag;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold_dat;

  logic cs_act;
  logic sclk_rise, sclk_fall, cs_on, cs_off;
  logic rx_en, tx_load, tx_shift_en;
  logic [7:0] rx_next;

  assign cs_act = (SPI_CS_POL != 0) ? i_spi_cs : ~i_spi_cs;

  // The CS chain resets to "asserted", so a CS still held active when reset
  // releases produces no cs_on; the master must deassert and reassert.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], i_spi_clk};
      cs_sync   <= {cs_sync[1:0], cs_act};
      mosi_sync <= {mosi_sync[0], i_spi_mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_on     = cs_sync[1] & ~cs_sync[2];
  assign cs_off    = ~cs_sync[1] & cs_sync[2];

  assign rx_en       = (state == ACTIVE) && !cs_off && sclk_rise;
  assign tx_load     = ((state == IDLE) && cs_on) ||
                       ((state == ACTIVE) && !cs_off && sclk_fall && byte_done);
  assign tx_shift_en = (state == ACTIVE) && !cs_off && sclk_fall && !byte_done;
  assign rx_next     = MSB_FIRST ? {rx_shift[6:0], mosi_sync[1]}
                                 : {mosi_sync[1], rx_shift[7:1]};

  assign o_spi_miso    = MSB_FIRST ? tx_shift[7] : tx_shift[0];
  assign o_spi_miso_oe = o_frame_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= 3'd0;
      byte_done      <= 1'b0;
      first_flag     <= 1'b0;
      rx_shift       <= 8'h00;
      tx_shift       <= 8'h00;
      hold_dat       <= 8'h00;
      o_tx_empty     <= 1'b1;
      ov_rx_data     <= 9'h000;
      o_rx_valid     <= 1'b0;
      o_tx_underrun  <= 1'b0;
      o_frame_active <= 1'b0;
      o_frame_end    <= 1'b0;
    end else begin
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
      o_frame_end   <= 1'b0;

      if (state == IDLE) begin
        if (cs_on) begin
          state          <= ACTIVE;
          o_frame_active <= 1'b1;
          first_flag     <= 1'b1;
          bit_cnt        <= 3'd0;
          byte_done      <= 1'b0;
        end
      end else if (cs_off) begin
        // A partial byte is simply abandoned; the shifter is overwritten next frame.
        state          <= IDLE;
        o_frame_active <= 1'b0;
        o_frame_end    <= 1'b1;
        bit_cnt        <= 3'd0;
        byte_done      <= 1'b0;
        first_flag     <= 1'b0;
      end else begin
        if (rx_en) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done  <= 1'b1;
            ov_rx_data <= {first_flag, rx_next};
            o_rx_valid <= 1'b1;
            first_flag <= 1'b0;
          end
        end
        if (sclk_fall && byte_done)
          byte_done <= 1'b0;
      end

      // A write that coincides with a load while full is dropped like any other.
      if (tx_load) begin
        if (!o_tx_empty) begin
          tx_shift   <= hold_dat;
          o_tx_empty <= 1'b1;
        end else if (i_tx_wr) begin
          tx_shift <= iv_tx_data;
        end else begin
          tx_shift      <= 8'h00;
          o_tx_underrun <= 1'b1;
        end
      end else begin
        if (tx_shift_en)
          tx_shift <= MSB_FIRST ? {tx_shift[6:0], 1'b0} : {1'b0, tx_shift[7:1]};
        if (i_tx_wr && o_tx_empty) begin
          hold_dat   <= iv_tx_data;
          o_tx_empty <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one MSB-first/active-low instance and one LSB-first/active-high
// instance, driven by a bit-banged mode-0 master at 16 clk per SPI period.
module tb_spi_slave;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_sclk, a_cs, a_mosi, a_miso, a_oe, a_rx_valid, a_wr, a_empty, a_unr, a_act, a_fe;
  logic [8:0] a_rx_data;
  logic [7:0] a_dat;
  logic       b_sclk, b_cs, b_mosi, b_miso, b_oe, b_rx_valid, b_wr, b_empty, b_unr, b_act, b_fe;
  logic [8:0] b_rx_data;
  logic [7:0] b_dat;

  spi_slave #(.SPI_FIRST_DATA("MSB"), .SPI_CS_POL(0)) dut_a (
    .clk(clk), .reset(reset), .i_spi_clk(a_sclk), .i_spi_cs(a_cs), .i_spi_mosi(a_mosi),
    .o_spi_miso(a_miso), .o_spi_miso_oe(a_oe), .ov_rx_data(a_rx_data), .o_rx_valid(a_rx_valid),
    .iv_tx_data(a_dat), .i_tx_wr(a_wr), .o_tx_empty(a_empty), .o_tx_underrun(a_unr),
    .o_frame_active(a_act), .o_frame_end(a_fe));

  spi_slave #(.SPI_FIRST_DATA("LSB"), .SPI_CS_POL(1)) dut_b (
    .clk(clk), .reset(reset), .i_spi_clk(b_sclk), .i_spi_cs(b_cs), .i_spi_mosi(b_mosi),
    .o_spi_miso(b_miso), .o_spi_miso_oe(b_oe), .ov_rx_data(b_rx_data), .o_rx_valid(b_rx_valid),
    .iv_tx_data(b_dat), .i_tx_wr(b_wr), .o_tx_empty(b_empty), .o_tx_underrun(b_unr),
    .o_frame_active(b_act), .o_frame_end(b_fe));

  int n_cmp = 0;
  int n_bad = 0;
  int unr_a = 0, fe_a = 0, fe_b = 0;
  logic [8:0] rxq_a[$];
  logic [8:0] rxq_b[$];

  always @(negedge clk) begin
    if (a_rx_valid) rxq_a.push_back(a_rx_data);
    if (b_rx_valid) rxq_b.push_back(b_rx_data);
    if (a_unr) unr_a++;
    if (a_fe) fe_a++;
    if (b_fe) fe_b++;
  end

  typedef struct {
    logic [7:0] mosi;
    bit         wr;
    logic [7:0] wr_dat;
    logic [8:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_unr;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rx(input bit use_b, input string name, input logic [8:0] exp);
    int sz;
    sz = use_b ? rxq_b.size() : rxq_a.size();
    chk({name, "_count"}, 32'(sz), 32'd1);
    if (sz > 0) chk(name, 32'(use_b ? rxq_b.pop_front() : rxq_a.pop_front()), 32'(exp));
  endtask

  task automatic tx_write(input bit use_b, input logic [7:0] d);
    @(negedge clk);
    if (use_b) begin b_wr = 1'b1; b_dat = d; end
    else begin a_wr = 1'b1; a_dat = d; end
    @(negedge clk);
    a_wr = 1'b0;
    b_wr = 1'b0;
  endtask

  task automatic wait_empty(input bit use_b);
    logic e;
    for (int i = 0; i < 40; i++) begin
      e = use_b ? b_empty : a_empty;
      if (e) break;
      @(negedge clk);
    end
    chk("tx_empty_wait", 32'(use_b ? b_empty : a_empty), 32'd1);
  endtask

  // Mode 0 master: data set while SCLK low, slave MISO sampled just after the rise.
  task automatic xfer(input bit use_b, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic [2:0] idx;
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = use_b ? 3'(i) : 3'(7 - i);
      if (use_b) b_mosi = tx[idx]; else a_mosi = tx[idx];
      repeat (8) @(negedge clk);
      if (use_b) b_sclk = 1'b1; else a_sclk = 1'b1;
      @(negedge clk);
      rx[idx] = use_b ? b_miso : a_miso;
      repeat (7) @(negedge clk);
      if (use_b) b_sclk = 1'b0; else a_sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"}, 32'(a_miso), 32'd0);
    chk({tag, "_miso_oe"}, 32'(a_oe), 32'd0);
    chk({tag, "_rx_data"}, 32'(a_rx_data), 32'd0);
    chk({tag, "_rx_valid"}, 32'(a_rx_valid), 32'd0);
    chk({tag, "_tx_empty"}, 32'(a_empty), 32'd1);
    chk({tag, "_tx_underrun"}, 32'(a_unr), 32'd0);
    chk({tag, "_frame_active"}, 32'(a_act), 32'd0);
    chk({tag, "_frame_end"}, 32'(a_fe), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int unr0, fe0, nrx;

    vt[0] = '{8'hA5, 1'b1, 8'hC3, 9'h1A5, 8'h5A, 0};
    vt[1] = '{8'h3C, 1'b0, 8'h00, 9'h03C, 8'hC3, 1};
    vt[2] = '{8'hFF, 1'b0, 8'h00, 9'h0FF, 8'h00, 2};
    vt[3] = '{8'h81, 1'b1, 8'h96, 9'h081, 8'h00, 2};
    vt[4] = '{8'h00, 1'b0, 8'h00, 9'h000, 8'h96, 3};

    reset = 1'b1;
    a_sclk = 0; a_cs = 1; a_mosi = 0; a_wr = 0; a_dat = 0;
    b_sclk = 0; b_cs = 0; b_mosi = 0; b_wr = 0; b_dat = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Multi-byte frame, MSB first, active-low CS
    tx_write(0, 8'h5A);
    chk("preload_full", 32'(a_empty), 32'd0);
    a_cs = 1'b0;
    repeat (8) @(negedge clk);
    chk("frame_active", 32'(a_act), 32'd1);
    chk("miso_oe", 32'(a_oe), 32'd1);
    unr0 = unr_a;
    fe0  = fe_a;
    for (int k = 0; k < 5; k++) begin
      if (vt[k].wr) begin
        wait_empty(0);
        tx_write(0, vt[k].wr_dat);
      end
      xfer(0, vt[k].mosi, 8, rx);
      chk($sformatf("tbl%0d_miso", k), 32'(rx), 32'(vt[k].exp_miso));
      check_rx(0, $sformatf("tbl%0d_rx", k), vt[k].exp_rx);
      chk($sformatf("tbl%0d_underruns", k), 32'(unr_a - unr0), 32'(vt[k].exp_unr));
    end
    a_cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("frame_inactive", 32'(a_act), 32'd0);
    chk("frame_end_pulses", 32'(fe_a - fe0), 32'd1);

    // LSB first, active-high CS
    tx_write(1, 8'hB4);
    b_cs = 1'b1;
    repeat (8) @(negedge clk);
    fe0 = fe_b;
    xfer(1, 8'h01, 8, rx);
    chk("lsb_miso0", 32'(rx), 32'hB4);
    check_rx(1, "lsb_rx0", 9'h101);
    xfer(1, 8'h80, 8, rx);
    chk("lsb_miso1", 32'(rx), 32'h00);
    check_rx(1, "lsb_rx1", 9'h080);
    b_cs = 1'b0;
    repeat (8) @(negedge clk);
    chk("lsb_frame_end", 32'(fe_b - fe0), 32'd1);

    // Bypass at the cs_on load: CS driven at n0, cs_on detect cycle is between n2 and the next posedge
    unr0 = unr_a;
    @(negedge clk); a_cs = 1'b0;
    @(negedge clk);
    @(negedge clk); a_wr = 1'b1; a_dat = 8'h77;
    @(negedge clk); a_wr = 1'b0;
    chk("bypass_empty", 32'(a_empty), 32'd1);
    @(negedge clk); a_wr = 1'b1; a_dat = 8'h11;
    @(negedge clk); a_dat = 8'h22;
    @(negedge clk); a_wr = 1'b0;
    chk("overflow_full", 32'(a_empty), 32'd0);
    repeat (4) @(negedge clk);
    xfer(0, 8'h34, 8, rx);
    chk("bypass_miso", 32'(rx), 32'h77);
    check_rx(0, "bypass_rx", 9'h134);
    chk("after_transfer_empty", 32'(a_empty), 32'd1);
    xfer(0, 8'h56, 8, rx);
    chk("overflow_miso", 32'(rx), 32'h11);
    check_rx(0, "overflow_rx", 9'h056);
    a_cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("bypass_underruns", 32'(unr_a - unr0), 32'd1);

    // Abort after 5 bits
    a_cs = 1'b0;
    repeat (8) @(negedge clk);
    nrx = rxq_a.size();
    fe0 = fe_a;
    xfer(0, 8'hFF, 5, rx);
    a_cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_rx", 32'(rxq_a.size()), 32'(nrx));
    chk("abort_frame_end", 32'(fe_a - fe0), 32'd1);
    a_cs = 1'b0;
    repeat (8) @(negedge clk);
    xfer(0, 8'h5C, 8, rx);
    check_rx(0, "after_abort_rx", 9'h15C);
    a_cs = 1'b1;
    repeat (8) @(negedge clk);

    // Reset mid-byte with CS held asserted through release
    tx_write(0, 8'hFF);
    a_cs = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_miso", 32'(a_miso), 32'd1);
    wait_empty(0);
    tx_write(0, 8'hE7);
    chk("pre_reset_full", 32'(a_empty), 32'd0);
    xfer(0, 8'hAA, 3, rx);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_cs_not_frame", 32'(a_act), 32'd0);
    nrx = rxq_a.size();
    fe0 = fe_a;
    xfer(0, 8'h42, 8, rx);
    chk("held_cs_no_rx", 32'(rxq_a.size()), 32'(nrx));
    chk("held_cs_oe", 32'(a_oe), 32'd0);
    a_cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("held_cs_no_frame_end", 32'(fe_a - fe0), 32'd0);
    a_cs = 1'b0;
    repeat (8) @(negedge clk);
    xfer(0, 8'h42, 8, rx);
    check_rx(0, "after_reset_rx", 9'h142);
    a_cs = 1'b1;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
